event_adder_arb: RTL and testbench

EVENT_ADDER_ARB -- requirements
Module: event_adder_arb

---
 rtl/event_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/event_adder_arb.sv | 126 ++++++++++++
 tb/tb_event_adder_arb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// Shared types and default parameters for the event adder / arbiter block.
// The output slot is either EMPTY (no result held) or FULL (result on sum_o/ch_o).
package event_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request found searching
// upward from ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic           gnt_valid,
  output logic [IW-1:0]  gnt_idx
);

  // Walk offsets from far to near so the nearest hit to ptr is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      logic [IW:0] pos;
      pos = {1'b0, ptr} + (IW + 1)'(i);
      if (pos >= (IW + 1)'(NCH)) begin
        pos = pos - (IW + 1)'(NCH);
      end
      if (req[pos[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/event_adder_arb.sv
// Per-channel pending-event counters feed a round-robin arbiter; each grant
// loads A+C of the winning channel into a one-entry output slot.
module event_adder_arb
  import event_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           ev_i,
  input  logic [NCH*WIDTH-1:0]     a_i,
  input  logic [NCH*WIDTH-1:0]     c_i,
  output logic [WIDTH:0]           sum_o,
  output logic [$clog2(NCH)-1:0]   ch_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [NCH-1:0]           drop_o,
  output logic                     busy_o
);

  localparam int IW = $clog2(NCH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_state_t      state_reg;
  logic [IW-1:0]    rr_ptr_reg;
  logic [NCH-1:0]   req;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_idx;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] c_sel;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A full slot can be refilled in the same cycle it is drained.
  assign grant = gnt_valid && ((state_reg == EMPTY) || ready_i);
  assign a_sel = a_i[gnt_idx*WIDTH +: WIDTH];
  assign c_sel = c_i[gnt_idx*WIDTH +: WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic             drop_reg;
      logic             dec;

      assign dec        = grant && (gnt_idx == IW'(gi));
      assign req[gi]    = |cnt_reg;
      assign drop_o[gi] = drop_reg;

      // A simultaneous event and grant cancel out, so a full counter only
      // loses an event when it is not being serviced that cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg  <= '0;
          drop_reg <= 1'b0;
        end else begin
          drop_reg <= 1'b0;
          if (ev_i[gi] && !dec) begin
            if (cnt_reg == CNT_MAX) begin
              drop_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else if (dec && !ev_i[gi]) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant) begin
      rr_ptr_reg <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      valid_o   <= 1'b0;
      sum_o     <= '0;
      ch_o      <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (grant) begin
            state_reg <= FULL;
            valid_o   <= 1'b1;
            sum_o     <= (WIDTH + 1)'(a_sel) + (WIDTH + 1)'(c_sel);
            ch_o      <= gnt_idx;
          end
        end
        FULL: begin
          if (grant) begin
            sum_o <= (WIDTH + 1)'(a_sel) + (WIDTH + 1)'(c_sel);
            ch_o  <= gnt_idx;
          end else if (ready_i) begin
            state_reg <= EMPTY;
            valid_o   <= 1'b0;
          end
        end
        default: begin
          state_reg <= EMPTY;
          valid_o   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = (|req) || valid_o;

endmodule

// File: tb/tb_event_adder_arb.sv
// Randomized and directed bench for event_adder_arb, checked cycle by cycle
// against a behavioural model of counters, round-robin order and output slot.
module tb_event_adder_arb;

  localparam int WIDTH = 4;
  localparam int NCH   = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NCH-1:0]         ev_i = '0;
  logic [NCH*WIDTH-1:0]   a_i = '0;
  logic [NCH*WIDTH-1:0]   c_i = '0;
  logic [WIDTH:0]         sum_o;
  logic [1:0]             ch_o;
  logic                   valid_o;
  logic                   ready_i = 1'b0;
  logic [NCH-1:0]         drop_o;
  logic                   busy_o;

  event_adder_arb #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_i    (ev_i),
    .a_i     (a_i),
    .c_i     (c_i),
    .sum_o   (sum_o),
    .ch_o    (ch_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .drop_o  (drop_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_drop3  = 0;

  // Reference state
  int m_cnt[NCH];
  int m_ptr;
  int m_valid;
  int m_sum;
  int m_ch;
  int m_drop;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
    m_ptr = 0; m_valid = 0; m_sum = 0; m_ch = 0; m_drop = 0;
  endtask

  function automatic int model_busy();
    int b;
    b = m_valid;
    for (int k = 0; k < NCH; k++) if (m_cnt[k] > 0) b = 1;
    return b;
  endfunction

  // One clock of the reference behaviour, using the inputs presented this cycle.
  task automatic model_step(input logic [NCH-1:0] ev, input logic rdy);
    int g;
    g = -1;
    if (m_valid == 0 || rdy) begin
      for (int off = NCH - 1; off >= 0; off--) begin
        int k;
        k = (m_ptr + off) % NCH;
        if (m_cnt[k] > 0) g = k;
      end
    end
    m_drop = 0;
    for (int k = 0; k < NCH; k++) begin
      if (ev[k] && g != k) begin
        if (m_cnt[k] == CMAX) m_drop |= (1 << k);
        else m_cnt[k]++;
      end else if (!ev[k] && g == k) begin
        m_cnt[k]--;
      end
    end
    if (g >= 0) begin
      m_sum   = int'((a_i >> (g * WIDTH)) & 4'hF) + int'((c_i >> (g * WIDTH)) & 4'hF);
      m_ch    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NCH;
    end else if (rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic tick(input logic [NCH-1:0] ev, input logic rdy,
                      input logic [NCH*WIDTH-1:0] a, input logic [NCH*WIDTH-1:0] c);
    @(negedge clk);
    ev_i = ev; ready_i = rdy; a_i = a; c_i = c;
    if (valid_o && rdy) begin
      n_acc++;
      $display("accept ch=%0d sum=%0d t=%0t", ch_o, sum_o, $time);
    end
    model_step(ev, rdy);
    @(posedge clk);
    #1;
    chk("valid", int'(valid_o), m_valid);
    chk("sum",   int'(sum_o),   m_sum);
    chk("ch",    int'(ch_o),    m_ch);
    chk("drop",  int'(drop_o),  m_drop);
    chk("busy",  int'(busy_o),  model_busy());
    if (drop_o[3]) n_drop3++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ev_i = '0;
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_sum",   int'(sum_o),   0);
    chk("rst_ch",    int'(ch_o),    0);
    chk("rst_drop",  int'(drop_o),  0);
    chk("rst_busy",  int'(busy_o),  0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [15:0] A_FIX = 16'hF350;
  localparam logic [15:0] C_FIX = 16'h274F;

  initial begin
    logic [WIDTH:0] held;
    model_reset();
    do_reset();

    // Single event on ch1: 5 + 4
    tick(4'b0010, 1'b1, 16'h0050, 16'h0040);
    tick(4'b0000, 1'b1, 16'h0050, 16'h0040);
    chk("single_sum", int'(sum_o), 9);
    chk("single_ch",  int'(ch_o),  1);
    tick(4'b0000, 1'b1, 16'h0050, 16'h0040);
    chk("single_busy", int'(busy_o), 0);

    // Overflow width on ch0: 15 + 15
    tick(4'b0001, 1'b1, 16'h000F, 16'h000F);
    tick(4'b0000, 1'b1, 16'h000F, 16'h000F);
    chk("ovf_sum", int'(sum_o), 30);
    tick(4'b0000, 1'b1, 16'h000F, 16'h000F);

    // Fairness from pointer 0
    do_reset();
    tick(4'b1111, 1'b1, A_FIX, C_FIX);
    for (int i = 0; i < NCH; i++) begin
      tick(4'b0000, 1'b1, A_FIX, C_FIX);
      chk("fair_ch", int'(ch_o), i);
    end
    tick(4'b0000, 1'b1, A_FIX, C_FIX);

    // Backpressure: three events on ch2 while the consumer stalls
    for (int i = 0; i < 3; i++) tick(4'b0100, 1'b0, A_FIX, C_FIX);
    held = sum_o;
    for (int i = 0; i < 2; i++) begin
      tick(4'b0000, 1'b0, A_FIX, C_FIX);
      chk("bp_hold", int'(sum_o), int'(held));
    end
    n_acc = 0;
    for (int i = 0; i < 5; i++) tick(4'b0000, 1'b1, A_FIX, C_FIX);
    chk("bp_results", n_acc, 3);

    // Saturation: nine events on ch3 into an empty slot
    n_drop3 = 0;
    for (int i = 0; i < 9; i++) tick(4'b1000, 1'b0, A_FIX, C_FIX);
    chk("sat_drops", n_drop3, 1);
    n_acc = 0;
    for (int i = 0; i < 12; i++) tick(4'b0000, 1'b1, A_FIX, C_FIX);
    chk("sat_results", n_acc, 8);

    // Reset with pending events and a held result
    tick(4'b0110, 1'b0, A_FIX, C_FIX);
    tick(4'b0110, 1'b0, A_FIX, C_FIX);
    chk("pre_rst_valid", int'(valid_o), 1);
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 4; i++) tick(4'b0000, 1'b1, A_FIX, C_FIX);
    chk("post_rst_results", n_acc, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] ev;
      logic rdy;
      ev  = NCH'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      tick(ev, rdy, 16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
